// File: rtl/pulse_tx.sv
// Pulse-width serial transmitter: each bit is a low space whose width encodes the bit,
// followed by a fixed-width high mark. LSB first, 8 bits per frame, all outputs registered.
module pulse_tx #(
    parameter int unsigned T1 = 3,
    parameter int unsigned T0 = 11,
    parameter int unsigned TM = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       dav,
    output logic       rfd,
    output logic       txd,
    output logic       done
);

    // Receiver decodes space <8 as 1 and >=8 as 0; mark must fit the 4-bit counter.
    if (T1 == 0 || T1 > 6) begin : g_bad_t1
        $error("pulse_tx: T1 must be in 1..6");
    end
    if (T0 < 9 || T0 > 14) begin : g_bad_t0
        $error("pulse_tx: T0 must be in 9..14");
    end
    if (TM < 3 || TM > 16) begin : g_bad_tm
        $error("pulse_tx: TM must be in 3..16");
    end

    localparam logic [3:0] W1     = 4'(T1 - 1);
    localparam logic [3:0] W0     = 4'(T0 - 1);
    localparam logic [3:0] WM     = 4'(TM - 1);
    // The final mark is one clock short: the IDLE cycle that follows supplies its last clock,
    // so back-to-back frames see exactly TM mark clocks between them.
    localparam logic [3:0] WMLAST = 4'(TM - 2);

    typedef enum logic [1:0] {
        StIdle,
        StSpace,
        StMark
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dav && rfd) begin
                    state_d = StSpace;
                    shift_d = byte_in;
                    idx_d   = 3'd0;
                    cnt_d   = byte_in[0] ? W1 : W0;
                end
            end
            StSpace: begin
                if (cnt_q == 4'd0) begin
                    state_d = StMark;
                    cnt_d   = (idx_q == 3'd7) ? WMLAST : WM;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StMark: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (idx_q == 3'd7) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = StSpace;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = shift_q[1] ? W1 : W0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            txd     <= 1'b1;
            rfd     <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd     <= (state_d != StSpace);
            rfd     <= (state_d == StIdle);
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_tx.sv
// Directed bench for pulse_tx: measures space/mark widths, frame length and done/rfd timing
// of captured frames against widths derived from the transmitted byte.
module tb_pulse_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       dav;
    logic       rfd;
    logic       txd;
    logic       done;

    int checks = 0;
    int errors = 0;

    int sp[8];
    int mk[8];
    int nsp, nmk, flen, lat, bad, done_end, ended;

    pulse_tx dut (
        .clock   (clock),
        .reset   (reset),
        .byte_in (byte_in),
        .dav     (dav),
        .rfd     (rfd),
        .txd     (txd),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after the transfer edge; samples on falling edges until the rfd=1 cycle.
    task automatic capture();
        int cur_sp;
        int cur_mk;
        lat = 0; nsp = 0; nmk = 0; flen = 0; bad = 0; done_end = 0; ended = 0;
        cur_sp = 0; cur_mk = 0;
        for (int i = 0; i < 8; i++) begin
            sp[i] = 0;
            mk[i] = 0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            lat++;
            if (txd === 1'b0) break;
        end
        if (txd !== 1'b0) return;
        flen   = 1;
        cur_sp = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            flen++;
            if (rfd === 1'b1) begin
                cur_mk++;
                if (nmk < 8) mk[nmk] = cur_mk;
                nmk++;
                done_end = (done === 1'b1) ? 1 : 0;
                if (txd !== 1'b1) bad++;
                ended = 1;
                break;
            end
            if (done !== 1'b0 || rfd !== 1'b0) bad++;
            if (txd === 1'b0) begin
                if (cur_mk > 0) begin
                    if (nmk < 8) mk[nmk] = cur_mk;
                    nmk++;
                    cur_mk = 0;
                end
                cur_sp++;
            end else begin
                if (cur_sp > 0) begin
                    if (nsp < 8) sp[nsp] = cur_sp;
                    nsp++;
                    cur_sp = 0;
                end
                cur_mk++;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] b);
        int total;
        capture();
        total = 0;
        check($sformatf("%s_latency", name), lat, 1);
        check($sformatf("%s_ended", name), ended, 1);
        check($sformatf("%s_nspaces", name), nsp, 8);
        check($sformatf("%s_nmarks", name), nmk, 8);
        for (int i = 0; i < 8; i++) begin
            total += (b[i] ? 3 : 11) + 4;
            check($sformatf("%s_space%0d", name, i), sp[i], b[i] ? 3 : 11);
            check($sformatf("%s_mark%0d", name, i), mk[i], 4);
        end
        check($sformatf("%s_frame_len", name), flen, total);
        check($sformatf("%s_midframe_bad", name), bad, 0);
        check($sformatf("%s_done_at_end", name), done_end, 1);
    endtask

    task automatic check_idle_after(input string name);
        @(negedge clock);
        check($sformatf("%s_done_one_cycle", name), done, 0);
        check($sformatf("%s_rfd_idle", name), rfd, 1);
        check($sformatf("%s_txd_idle", name), txd, 1);
    endtask

    initial begin
        int misc;
        reset   = 1'b1;
        dav     = 1'b0;
        byte_in = 8'h00;

        // Reset for two cycles; dav during reset must not start a frame.
        @(negedge clock);
        check("rst_txd", txd, 1);
        check("rst_rfd", rfd, 1);
        check("rst_done", done, 0);
        dav     = 1'b1;
        byte_in = 8'h00;
        @(negedge clock);
        check("rst_dav_txd", txd, 1);
        check("rst_dav_rfd", rfd, 1);
        dav   = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("idle_txd", txd, 1);

        // All-ones frame; byte_in changes mid-frame must not matter.
        byte_in = 8'hFF;
        dav     = 1'b1;
        @(posedge clock);
        #1;
        dav     = 1'b0;
        byte_in = 8'h00;
        check_frame("ff", 8'hFF);
        check_idle_after("ff");

        byte_in = 8'hA5;
        dav     = 1'b1;
        @(posedge clock);
        #1;
        dav     = 1'b0;
        byte_in = 8'h5A;
        check_frame("a5", 8'hA5);
        check_idle_after("a5");

        // Back-to-back: dav held high across the frame boundary.
        byte_in = 8'h00;
        dav     = 1'b1;
        @(posedge clock);
        #1;
        byte_in = 8'hFF;
        check_frame("b2b0", 8'h00);
        @(posedge clock);
        #1;
        dav = 1'b0;
        check_frame("b2b1", 8'hFF);
        check_idle_after("b2b1");

        // Reset during the space of bit 4 of 8'h00 (cycles 60..70 of the frame).
        byte_in = 8'h00;
        dav     = 1'b1;
        @(posedge clock);
        #1;
        dav = 1'b0;
        repeat (63) @(negedge clock);
        check("abort_in_space", txd, 0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_txd", txd, 1);
        check("abort_rfd", rfd, 1);
        check("abort_done", done, 0);
        reset = 1'b0;
        misc  = 0;
        repeat (20) begin
            @(negedge clock);
            if (done !== 1'b0 || txd !== 1'b1 || rfd !== 1'b1) misc++;
        end
        check("abort_quiet", misc, 0);

        byte_in = 8'h3C;
        dav     = 1'b1;
        @(posedge clock);
        #1;
        dav = 1'b0;
        check_frame("post_abort", 8'h3C);
        check_idle_after("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_tx.md
PULSE_TX -- requirements
Module: pulse_tx

Interface
REQ-001 Parameter T1, default 3: clocks of space per bit of value 1.
REQ-002 Parameter T0, default 11: clocks of space per bit of value 0.
REQ-003 Parameter TM, default 4: clocks of mark following every bit.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 byte_in  input  8  byte to transmit; sampled only at transfer.
REQ-007 dav  input  1  data valid from producer.
REQ-008 rfd  output  1  ready for data.
REQ-009 txd  output  1  serial line to the pulse-width receiver; mark=1, space=0.
REQ-010 done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Parameter legality: 1<=T1<=6, 9<=T0<=14, TM>=3; the downstream receiver decodes space <8 clocks as 1 and >=8 as 0, with a 4-bit counter; elaboration shall fail outside these ranges.
REQ-012 All outputs are registered; no combinational path from inputs to outputs.
REQ-013 States: IDLE, SPACE, MARK.
REQ-014 IDLE: txd=1, rfd=1.
REQ-015 Transfer occurs at a rising edge where dav=1 and rfd=1: byte_in latched into a shift register, bit index cleared, IDLE->SPACE, rfd=0.
REQ-016 SPACE: txd=0 for exactly T1 clocks if current bit (shift register LSB) is 1, else T0 clocks; then SPACE->MARK.
REQ-017 MARK: txd=1 for exactly TM clocks; then shift register shifts right, bit index increments.
REQ-018 Bit order LSB first; 8 bits per frame, no start/stop bits, no parity.
REQ-019 After MARK of bit index 7: MARK->IDLE, rfd=1, done=1 for that one cycle.
REQ-020 Frame length = sum of space widths + 8*TM clocks, measured from the first txd=0 cycle to the first rfd=1 cycle.
REQ-021 txd goes 0 in the first cycle after the transfer edge (latency 1).
REQ-022 dav while rfd=0 is ignored; byte_in changes during a frame have no effect.
REQ-023 Back-to-back: dav held 1 at the edge where rfd is 1 starts the next frame immediately; the inter-frame mark equals TM exactly.
REQ-024 The space-width counter is 4 bits and the bit index 3 bits; neither shall wrap within a legal frame.
REQ-025 done and rfd=1 are never asserted in SPACE or MARK.

Reset
REQ-026 reset=1 at a rising edge: state IDLE, txd=1, rfd=1, done=0, counters and shift register 0.
REQ-027 reset mid-frame aborts the frame; txd=1 from the next cycle; no done pulse.
REQ-028 reset has priority over transfer in the same edge; dav is ignored in that cycle.

Verification
REQ-029 Reset for 2 cycles -> txd=1, rfd=1, done=0 after the first edge.
REQ-030 byte_in=8'hFF transfer -> 8 spaces of 3 clocks, each followed by 4 mark clocks; done one cycle at frame end; frame = 56 clocks.
REQ-031 byte_in=8'hA5 -> space widths in order 3,11,3,11,11,3,11,3; frame = 88 clocks.
REQ-032 dav held 1 with 8'h00 then 8'hFF -> first frame 120 clocks; second frame's first txd=0 exactly 4 mark clocks after the last space of the first frame.
REQ-033 reset pulsed during bit 4 space of 8'h00 -> txd=1 the next cycle, rfd=1, no done; a new transfer afterwards produces a complete, correct frame.
REQ-034 Loopback into the pulse-width receiver with ref=5'b10110, byte_in=8'b10110011 -> receiver LED=3'b011; with byte_in=8'b00110011 -> LED unchanged.
